// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - shared widths and encodings for the logical-unit writeback path
//
// Provides default FIFO depth, register address width, result width, FIFO entry
// width and the precision encodings carried alongside each writeback.
// Optional feature macro used by logic_wb_buffer: LOGIC_WB_BYPASS_EN.

package logic_pkg;

    localparam int WB_DEPTH      = 4;
    localparam int LOGIC_ADDR_W  = 6;
    localparam int LOGIC_DATA_W  = 128;
    localparam int LOGIC_ENTRY_W = LOGIC_DATA_W + LOGIC_ADDR_W + 1;

    localparam logic PREC_32 = 1'b1;
    localparam logic PREC_16 = 1'b0;

endpackage

// File: rtl/logic_wb_fifo.sv
// rtl/logic_wb_fifo.sv - generic synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous flush (wins over push/pop)
//   push         write push_data at tail (ignored when full and not popping)
//   push_data    entry to write
//   pop          retire head entry (ignored when empty)
//   head_data    current head entry
//   count        number of stored entries, 0..DEPTH
//   full, empty  count==DEPTH / count==0
// DEPTH must be a power of two so the pointers wrap naturally.

module logic_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/logic_wb_buffer.sv
// rtl/logic_wb_buffer.sv - writeback buffer between logical_unit and the vector register file
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   iss_vld/iss_dst/iss_prec  issued logical micro-op and its destination tag
//   iss_rdy               issue credit (combinational)
//   dr_logic_d            registered result, valid the cycle after issue
//   clr                   synchronous flush of tag, FIFO and ovf_err
//   wb_vld/wb_rdy         writeback handshake
//   wb_addr/wb_data/wb_prec  writeback payload
//   ovf_err               sticky: issue attempted without credit
// Configuration macro: LOGIC_WB_BYPASS_EN - when defined, a result arriving while
// the FIFO is empty is presented in the same cycle (latency 1) instead of via the FIFO.

module logic_wb_buffer
    import logic_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = LOGIC_ADDR_W,
    parameter int DATA_W = LOGIC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_vld,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              iss_prec,
    output logic              iss_rdy,
    input  logic [DATA_W-1:0] dr_logic_d,
    input  logic              clr,
    output logic              wb_vld,
    input  logic              wb_rdy,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_prec,
    output logic              ovf_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DATA_W + ADDR_W + 1;

    logic              p_vld;
    logic [ADDR_W-1:0] p_addr;
    logic              p_prec;

    logic              iss_acc;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    // The op sitting in the pending tag register is already committed to a FIFO
    // slot, so it is counted against the credit along with the stored entries.
    assign iss_rdy = ({1'b0, count} + {{CW{1'b0}}, p_vld}) < (CW+1)'(DEPTH);
    assign iss_acc = iss_vld & iss_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld   <= 1'b0;
            p_addr  <= '0;
            p_prec  <= 1'b0;
            ovf_err <= 1'b0;
        end else if (clr) begin
            p_vld   <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            p_vld <= iss_acc;
            if (iss_acc) begin
                p_addr <= iss_dst;
                p_prec <= iss_prec;
            end
            if (iss_vld && !iss_rdy) begin
                ovf_err <= 1'b1;
            end
        end
    end

`ifdef LOGIC_WB_BYPASS_EN
    logic byp;

    // Bypass only with an empty FIFO so results never overtake buffered ones.
    assign byp = empty & p_vld;

    always_comb begin
        wb_vld  = ~empty;
        wb_data = head[EW-1 -: DATA_W];
        wb_addr = head[ADDR_W:1];
        wb_prec = head[0];
        if (byp) begin
            wb_vld  = 1'b1;
            wb_data = dr_logic_d;
            wb_addr = p_addr;
            wb_prec = p_prec;
        end
    end

    // A bypassed result taken by the register file is never stored.
    assign push = p_vld & ~(byp & wb_rdy) & (~full | pop);
`else
    always_comb begin
        wb_vld  = ~empty;
        wb_data = head[EW-1 -: DATA_W];
        wb_addr = head[ADDR_W:1];
        wb_prec = head[0];
    end

    // Credit guarantees room; the full term only guards against misuse.
    assign push = p_vld & (~full | pop);
`endif

    assign pop = wb_vld & wb_rdy & ~empty;

    logic_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data ({dr_logic_d, p_addr, p_prec}),
        .pop       (pop),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_logic_wb_buffer.sv
// tb/tb_logic_wb_buffer.sv - self-checking bench for logic_wb_buffer

module tb_logic_wb_buffer;
    import logic_pkg::*;

    localparam int D = 4;
`ifdef LOGIC_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iss_vld = 1'b0;
    logic [5:0]   iss_dst = '0;
    logic         iss_prec = 1'b0;
    logic         iss_rdy;
    logic [127:0] dr_logic_d = '0;
    logic         clr = 1'b0;
    logic         wb_vld;
    logic         wb_rdy = 1'b0;
    logic [5:0]   wb_addr;
    logic [127:0] wb_data;
    logic         wb_prec;
    logic         ovf_err;

    always #5 clk = ~clk;

    logic_wb_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_vld    (iss_vld),
        .iss_dst    (iss_dst),
        .iss_prec   (iss_prec),
        .iss_rdy    (iss_rdy),
        .dr_logic_d (dr_logic_d),
        .clr        (clr),
        .wb_vld     (wb_vld),
        .wb_rdy     (wb_rdy),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_prec    (wb_prec),
        .ovf_err    (ovf_err)
    );

    typedef struct packed {
        logic [5:0]   addr;
        logic [127:0] data;
        logic         prec;
    } exp_t;

    typedef struct packed {
        logic       v;
        logic [5:0] dst;
        logic       prec;
        logic       rdy;
        logic       exp_rdy;
        logic       exp_wbv;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[10];
    int           checks = 0;
    int           failures = 0;
    int           outst = 0;
    bit           p_now = 1'b0;
    bit           ovf_m = 1'b0;
    bit           pend_v = 1'b0;
    logic [127:0] pend_d = '0;
    bit           use_a5 = 1'b0;
    bit           s_rdy, s_wbv, s_hs, s_ovf;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit m_rdy();
        return outst < D;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        sb.delete();
        outst  = 0;
        p_now  = 1'b0;
        ovf_m  = 1'b0;
        pend_v = 1'b0;
    endtask

    // One clock: drive after the edge, sample and score on the falling edge.
    task automatic cycle(input bit v, input logic [5:0] dst, input bit prec, input bit rdy, input bit c);
        exp_t         e;
        bit           exp_rdy, exp_wbv, acc;
        logic [127:0] nd;
        #1;
        iss_vld    = v;
        iss_dst    = dst;
        iss_prec   = prec;
        wb_rdy     = rdy;
        clr        = c;
        dr_logic_d = pend_v ? pend_d : rnd128();
        @(negedge clk);
        exp_rdy = (outst < D);
        exp_wbv = BYP ? (outst > 0) : ((outst - int'(p_now)) > 0);
        s_rdy = iss_rdy;
        s_wbv = wb_vld;
        s_hs  = wb_vld & rdy;
        s_ovf = ovf_err;
        chk("iss_rdy", iss_rdy, exp_rdy);
        chk("wb_vld", wb_vld, exp_wbv);
        chk("ovf_err", ovf_err, ovf_m);
        if (wb_vld && rdy && !c) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=addr %0h required=no writeback", wb_addr);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", wb_addr, e.addr);
                chk("wb_data", wb_data, e.data);
                chk("wb_prec", wb_prec, e.prec);
                outst--;
            end
        end
        acc = v & exp_rdy;
        if (v && !exp_rdy) ovf_m = 1'b1;
        nd     = use_a5 ? {16{8'hA5}} : rnd128();
        pend_v = acc && !c;
        pend_d = nd;
        if (acc && !c) begin
            sb.push_back('{dst, nd, prec});
            outst++;
        end
        p_now = acc && !c;
        if (c) model_reset();
        @(posedge clk);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && outst > 0; i++) cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int accepted;
        bit v;

        tbl = '{
            '{1'b1, 6'd10, 1'b1, 1'b0, 1'b1, 1'b0},
            '{1'b1, 6'd11, 1'b0, 1'b0, 1'b1, BYP },
            '{1'b1, 6'd12, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b1, 6'd13, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b1},
            '{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0}
        };

        // Reset state
        #2;
        chk("rst_wb_vld", wb_vld, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_prec", wb_prec, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_iss_rdy", iss_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Single op, A5 pattern result
        use_a5 = 1'b1;
        cycle(1'b1, 6'd5, PREC_32, 1'b1, 1'b0);
        use_a5 = 1'b0;
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("single_lat1", s_hs, BYP);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("single_lat2", s_hs, !BYP);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("single_empty", s_wbv, 0);

        // Burst of 4 under stall, then release
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].dst, tbl[i].prec, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_iss_rdy", i), s_rdy, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_wb_vld", i), s_wbv, tbl[i].exp_wbv);
        end
        chk("burst_sb_empty", sb.size(), 0);

        // Full FIFO with simultaneous push and pop, pointers wrap
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(20 + i), 1'(i), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) cycle(m_rdy(), 6'(24 + i), 1'(i), 1'b1, 1'b0);
        drain("full_pp_drain");

        // Overflow, sticky error, contents intact, then flush
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(30 + i), 1'(i), 1'b0, 1'b0);
        cycle(1'b1, 6'd40, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", s_ovf, 1);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        chk("ovf_sticky", s_ovf, 1);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", s_ovf, 0);
        chk("clr_wb_vld", s_wbv, 0);

        // Reset with three entries buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 6'(50 + i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_vld", wb_vld, 0);
        chk("midrst_iss_rdy", iss_rdy, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);

        // Random stall against the scoreboard
        accepted = 0;
        for (int cyc = 0; cyc < 20000 && accepted < 1000; cyc++) begin
            v = ($urandom_range(3) != 0) && m_rdy();
            cycle(v, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            if (v) accepted++;
        end
        chk("rand_accepted", accepted, 1000);
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
